mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// - Parametrised load/store unit plus banked data RAM for the OpenMIPS MEM stage; next generation of the fixed 4-bank data RAM.
// - Implements all MIPS32 byte/half/word loads and stores, including unaligned LWL/LWR/SWL/SWR, on a big-endian word layout.
// - Adds a valid/ready request handshake, a configurable read latency, synchronous flush, and a misaligned-address error response.
// PARAMETERS
// - ADDR_W      32  byte-address width
// - DEPTH_LOG2  10  log2 of RAM depth in 32-bit words
// - RD_LATENCY  1   cycles from load acceptance to resp_valid; legal range 1..4
// - ALIGN_CHECK 1   1: misaligned LH/LHU/SH/LW/SW raise resp_err; 0: low address bits are ignored
// PORTS
// - clk           in   1       clock; all state changes on posedge
// - rst           in   1       asynchronous, active-high reset
// - req_valid     in   1       request present
// - req_ready     out  1       request accepted when req_valid && req_ready at posedge
// - req_op        in   4       operation code (`MEM_OP_*)
// - req_addr      in   ADDR_W  byte address
// - req_wdata     in   32      rt value: store data, and merge source for LWL/LWR
// - flush         in   1       synchronous abort of an in-flight load; a request is never accepted in a flush cycle
// - resp_valid    out  1       one-cycle response strobe
// - resp_rdata    out  32      extended/merged load result; 0 for stores and errors
// - resp_err      out  1       misaligned access; qualified by resp_valid
// - resp_badaddr  out  ADDR_W  faulting address; qualified by resp_err
// - busy          out  1       high in RD_WAIT; the pipeline stalls on it
// BEHAVIOUR
// - Reset: state=IDLE; resp_valid, resp_err and busy =0; resp_rdata and resp_badaddr =0; req_ready=0 while rst is high. RAM contents are not reset (reads return X).
// - FSM states: IDLE, RD_WAIT, RESP. req_ready = ~flush && (IDLE || RESP), so a new request can be accepted back-to-back in the RESP cycle.
// - Word index = req_addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses wrap modulo the RAM depth.
// - Byte order: offset 0 is bits [31:24] (bank3); offset 3 is bits [7:0] (bank0).
// - Store (SB/SH/SW/SWL/SWR), accepted at edge t0:
//   - byte lanes are written at t0;
//   - next state RESP; resp_valid in the cycle after t0, with resp_rdata=0.
// - Store lane selects (sel[3:0]):
//   - SB: one lane, rt[7:0] replicated. SH: 1100 / 0011, rt[15:0] replicated. SW: 1111.
//   - SWL off n: sel = 1111>>n, data = rt>>(8n).
//   - SWR off n: sel = 1111<<(3-n) (4 bits kept), data = rt<<(8(3-n)).
// - Load, accepted at t0:
//   - RAM read is issued at t0; resp_valid is high exactly RD_LATENCY cycles after t0;
//   - FSM passes through RD_WAIT for RD_LATENCY-1 cycles (RD_LATENCY=1 goes straight to RESP).
// - Load results:
//   - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the whole word.
//   - LWL off n: {mem<<8n} | (rt & ~(FFFFFFFF<<8n)).
//   - LWR off n: {mem>>8(3-n)} | (rt & ~(FFFFFFFF>>8(3-n))).
//   - req_op and offset are registered at acceptance and used when the response is formed.
// - Misaligned access (ALIGN_CHECK=1):
//   - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0;
//   - no RAM access; resp_valid and resp_err in the cycle after t0; resp_badaddr=req_addr.
// - Illegal req_op: treated as a no-op; resp_valid next cycle with rdata=0 and err=0.
// - flush:
//   - in RD_WAIT/RESP: returns the FSM to IDLE at the next edge and suppresses resp_valid;
//   - a store that was already written is not undone.
// - Reset asserted mid-operation: the request is dropped at once and no response is issued.
// - Only one request is outstanding at a time; no forwarding is needed.
// STRUCTURE
// - Shared header mem_ops.vh: `MEM_OP_LB=4'h0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6, SB=8, SH=9, SW=A, SWL=B, SWR=C; state encodings.
// - Sub-module byte_bank_ram: 4 x 8-bit banks, per-lane write enable, registered read with a RD_LATENCY-deep pipeline.
// - Top level holds the FSM, latency counter, lane-select/alignment decode and the load extend/merge mux.
// TESTING
// - SB 0xFF @3, SB 0xEE @2, then LBU @3 -> 0x000000FF; LB @3 -> 0xFFFFFFFF; LHU @2 -> 0x0000EEFF.
// - SW 0x44556677 @8; LWL @9 with rt=0xBB889900 -> 0x556677 00; LWR @9 with rt=0xBB889900 -> 0xBB884455.
// - SWL 0xAABBCCDD @5 over 0 -> word@4=0x00AABBCC; SWR 0x11223344 @6 over it -> word@4=0x223344CC.
// - LH @1, ALIGN_CHECK=1 -> next cycle resp_err=1, resp_badaddr=1, no RAM change; LW @0x1004 (DEPTH_LOG2=10) returns word@4.
// - RD_LATENCY=3: LW accepted at t0 -> busy for 2 cycles, resp_valid at t0+3; flush at t0+1 -> no resp_valid, req_ready at t0+2.
// - Back-to-back: SW accepted in the RESP cycle of a load, both with correct data; rst pulsed in RD_WAIT -> outputs 0, no response.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: operation codes,
// FSM state encoding and small opcode-decode helpers.
package mem_access_unit_pkg;

  localparam logic [3:0] MEM_OP_LB  = 4'h0;
  localparam logic [3:0] MEM_OP_LBU = 4'h1;
  localparam logic [3:0] MEM_OP_LH  = 4'h2;
  localparam logic [3:0] MEM_OP_LHU = 4'h3;
  localparam logic [3:0] MEM_OP_LW  = 4'h4;
  localparam logic [3:0] MEM_OP_LWL = 4'h5;
  localparam logic [3:0] MEM_OP_LWR = 4'h6;
  localparam logic [3:0] MEM_OP_SB  = 4'h8;
  localparam logic [3:0] MEM_OP_SH  = 4'h9;
  localparam logic [3:0] MEM_OP_SW  = 4'hA;
  localparam logic [3:0] MEM_OP_SWL = 4'hB;
  localparam logic [3:0] MEM_OP_SWR = 4'hC;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op <= MEM_OP_LWR);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= MEM_OP_SB) && (op <= MEM_OP_SWR);
  endfunction

  // Halfword ops need an even address, word ops a word-aligned one.
  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return off[0];
      MEM_OP_LW, MEM_OP_SW:             return |off;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/byte_bank_ram.sv
// Four 8-bit RAM banks forming big-endian 32-bit words (bank3 = bits 31:24).
// Ports:
//   clk   - clock
//   we    - per-lane write enable (bit b writes bank b)
//   addr  - word index, shared by read and write
//   wdata - write data, lane b in bits [8b+7:8b]
//   re    - read enable; captures the addressed word
//   rdata - read word, valid RD_LATENCY edges after the re edge
module byte_bank_ram #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic                  re,
  output logic [31:0]           rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] stage0;

  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [7:0] mem [DEPTH];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (we[b]) begin
        mem[addr] <= wdata[8*b +: 8];
      end
      if (re) begin
        q <= mem[addr];
      end
    end

    assign stage0[8*b +: 8] = q;
  end

  // Extra register stages stretch the read to the configured latency.
  if (RD_LATENCY <= 1) begin : g_lat1
    assign rdata = stage0;
  end else begin : g_latn
    logic [31:0] pipe [RD_LATENCY-1];

    always_ff @(posedge clk) begin
      pipe[0] <= stage0;
      for (int unsigned i = 1; i < RD_LATENCY - 1; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end

    assign rdata = pipe[RD_LATENCY-2];
  end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS32 load/store unit with banked data RAM for the MEM stage.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   req_valid     - request present; accepted when req_valid && req_ready
//   req_ready     - unit can accept a request this cycle
//   req_op        - MEM_OP_* operation code
//   req_addr      - byte address (wraps modulo RAM depth)
//   req_wdata     - rt: store data and LWL/LWR merge source
//   flush         - synchronous abort of an in-flight access
//   resp_valid    - one-cycle response strobe
//   resp_rdata    - load result; 0 for stores, errors and no-ops
//   resp_err      - misaligned access
//   resp_badaddr  - faulting address when resp_err
//   busy          - waiting on a multi-cycle read
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              flush,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] resp_badaddr,
  output logic              busy
);

  state_t            state, state_nx;
  logic [2:0]        wait_cnt;
  logic [3:0]        op_q;
  logic [1:0]        off_q;
  logic [31:0]       rt_q;
  logic              err_q;
  logic              load_q;
  logic [ADDR_W-1:0] badaddr_q;

  logic        accept, is_ld, is_st, mis;
  logic [1:0]  off;
  logic [3:0]  sel;
  logic [31:0] sdata;
  logic [3:0]  ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic [31:0] ld_result;

  assign off    = req_addr[1:0];
  assign is_ld  = op_is_load(req_op);
  assign is_st  = op_is_store(req_op);
  assign mis    = (ALIGN_CHECK != 0) && op_misaligned(req_op, off);

  assign req_ready  = !rst && !flush && (state == IDLE || state == RESP);
  assign accept     = req_valid && req_ready;
  assign busy       = (state == RD_WAIT);
  assign resp_valid = (state == RESP) && !flush;
  assign resp_err   = resp_valid && err_q;
  assign resp_badaddr = resp_err ? badaddr_q : '0;
  assign resp_rdata   = (resp_valid && load_q) ? ld_result : '0;

  // Store lane select and byte placement, big-endian (offset 0 = bank3).
  always_comb begin
    sel   = '0;
    sdata = '0;
    case (req_op)
      MEM_OP_SB: begin
        sel   = 4'b1000 >> off;
        sdata = {4{req_wdata[7:0]}};
      end
      MEM_OP_SH: begin
        sel   = off[1] ? 4'b0011 : 4'b1100;
        sdata = {2{req_wdata[15:0]}};
      end
      MEM_OP_SW: begin
        sel   = 4'b1111;
        sdata = req_wdata;
      end
      MEM_OP_SWL: begin
        sel   = 4'b1111 >> off;
        sdata = req_wdata >> {off, 3'b000};
      end
      MEM_OP_SWR: begin
        sel   = 4'b1111 << (2'd3 - off);
        sdata = req_wdata << {~off, 3'b000};
      end
      default: ;
    endcase
  end

  assign ram_we = (accept && is_st && !mis) ? sel : '0;
  assign ram_re = accept && is_ld && !mis;

  byte_bank_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .RD_LATENCY (RD_LATENCY)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (req_addr[DEPTH_LOG2+1:2]),
    .wdata (sdata),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

  // Load extend/merge, using op/offset/rt captured at acceptance.
  always_comb begin
    logic [31:0] shl;
    logic [15:0] half;
    logic [4:0]  sh_l, sh_r;
    sh_l = {off_q, 3'b000};
    sh_r = {~off_q, 3'b000};
    shl  = ram_rdata << sh_l;
    half = off_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];
    ld_result = '0;
    case (op_q)
      MEM_OP_LB:  ld_result = {{24{shl[31]}}, shl[31:24]};
      MEM_OP_LBU: ld_result = {24'h0, shl[31:24]};
      MEM_OP_LH:  ld_result = {{16{half[15]}}, half};
      MEM_OP_LHU: ld_result = {16'h0, half};
      MEM_OP_LW:  ld_result = ram_rdata;
      MEM_OP_LWL: ld_result = shl | (rt_q & ~(32'hFFFF_FFFF << sh_l));
      MEM_OP_LWR: ld_result = (ram_rdata >> sh_r) | (rt_q & ~(32'hFFFF_FFFF >> sh_r));
      default:    ld_result = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          state_nx = (is_ld && !mis && RD_LATENCY > 1) ? RD_WAIT : RESP;
        end else begin
          state_nx = IDLE;
        end
      end
      RD_WAIT: begin
        if (flush) begin
          state_nx = IDLE;
        end else if (wait_cnt == 3'd1) begin
          state_nx = RESP;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // wait_cnt counts the RD_WAIT cycles still to go before RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      op_q      <= '0;
      off_q     <= '0;
      rt_q      <= '0;
      err_q     <= 1'b0;
      load_q    <= 1'b0;
      badaddr_q <= '0;
    end else if (accept) begin
      wait_cnt  <= 3'(RD_LATENCY - 1);
      op_q      <= req_op;
      off_q     <= off;
      rt_q      <= req_wdata;
      err_q     <= mis;
      load_q    <= is_ld && !mis;
      badaddr_q <= req_addr;
    end else if (state == RD_WAIT) begin
      wait_cnt  <= wait_cnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: RD_LATENCY=1
  logic        a_valid, a_ready, a_flush, a_rv, a_err, a_busy;
  logic [3:0]  a_op;
  logic [31:0] a_addr, a_wdata, a_rd, a_bad;
  // Instance B: RD_LATENCY=3
  logic        b_valid, b_ready, b_flush, b_rv, b_err, b_busy;
  logic [3:0]  b_op;
  logic [31:0] b_addr, b_wdata, b_rd, b_bad;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(
    .ADDR_W(32), .DEPTH_LOG2(10), .RD_LATENCY(1), .ALIGN_CHECK(1)
  ) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready),
    .req_op(a_op), .req_addr(a_addr), .req_wdata(a_wdata), .flush(a_flush),
    .resp_valid(a_rv), .resp_rdata(a_rd), .resp_err(a_err),
    .resp_badaddr(a_bad), .busy(a_busy)
  );

  mem_access_unit #(
    .ADDR_W(32), .DEPTH_LOG2(10), .RD_LATENCY(3), .ALIGN_CHECK(1)
  ) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
    .req_op(b_op), .req_addr(b_addr), .req_wdata(b_wdata), .flush(b_flush),
    .resp_valid(b_rv), .resp_rdata(b_rd), .resp_err(b_err),
    .resp_badaddr(b_bad), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request to A for one edge; returns just after acceptance.
  task automatic a_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    a_valid = 1'b1; a_op = op; a_addr = addr; a_wdata = wd;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic b_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    b_valid = 1'b1; b_op = op; b_addr = addr; b_wdata = wd;
    tick();
    b_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; a_op = 0; a_addr = 0; a_wdata = 0; a_flush = 0;
    b_valid = 0; b_op = 0; b_addr = 0; b_wdata = 0; b_flush = 0;
    tick();
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_rv",    32'(a_rv),    32'd0);
    chk("rst_busy",  32'(a_busy),  32'd0);
    chk("rst_err",   32'(a_err),   32'd0);
    chk("rst_rdata", a_rd,         32'd0);
    chk("rst_bad",   a_bad,        32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(a_ready), 32'd1);

    // Byte stores and loads
    a_req(4'hA, 32'h0, 32'h1234_5678);
    chk("sw0_rv", 32'(a_rv), 32'd1);
    chk("sw0_rd", a_rd, 32'd0);
    a_req(4'h8, 32'h3, 32'h0000_00FF);
    a_req(4'h8, 32'h2, 32'h0000_00EE);
    a_req(4'h1, 32'h3, 32'h0);
    chk("lbu3", a_rd, 32'h0000_00FF);
    a_req(4'h0, 32'h3, 32'h0);
    chk("lb3", a_rd, 32'hFFFF_FFFF);
    a_req(4'h3, 32'h2, 32'h0);
    chk("lhu2", a_rd, 32'h0000_EEFF);
    a_req(4'h2, 32'h2, 32'h0);
    chk("lh2", a_rd, 32'hFFFF_EEFF);
    a_req(4'h0, 32'h0, 32'h0);
    chk("lb0", a_rd, 32'h0000_0012);
    a_req(4'h4, 32'h0, 32'h0);
    chk("lw0", a_rd, 32'h1234_EEFF);
    tick();
    chk("idle_rv", 32'(a_rv), 32'd0);

    // Unaligned loads
    a_req(4'hA, 32'h8, 32'h4455_6677);
    a_req(4'h5, 32'h9, 32'hBB88_9900);
    chk("lwl9", a_rd, 32'h5566_7700);
    a_req(4'h6, 32'h9, 32'hBB88_9900);
    chk("lwr9", a_rd, 32'hBB88_4455);

    // Unaligned stores
    a_req(4'hA, 32'h4, 32'h0);
    a_req(4'hB, 32'h5, 32'hAABB_CCDD);
    a_req(4'h4, 32'h4, 32'h0);
    chk("swl5", a_rd, 32'h00AA_BBCC);
    a_req(4'hC, 32'h6, 32'h1122_3344);
    a_req(4'h4, 32'h4, 32'h0);
    chk("swr6", a_rd, 32'h2233_44CC);
    a_req(4'h4, 32'h1004, 32'h0);
    chk("wrap", a_rd, 32'h2233_44CC);

    // Misaligned accesses
    a_req(4'h2, 32'h1, 32'h0);
    chk("lh1_rv",  32'(a_rv),  32'd1);
    chk("lh1_err", 32'(a_err), 32'd1);
    chk("lh1_bad", a_bad, 32'h1);
    chk("lh1_rd",  a_rd,  32'h0);
    a_req(4'hA, 32'h2, 32'hDEAD_BEEF);
    chk("sw2_err", 32'(a_err), 32'd1);
    chk("sw2_bad", a_bad, 32'h2);
    a_req(4'h4, 32'h0, 32'h0);
    chk("mis_noram", a_rd, 32'h1234_EEFF);
    chk("ok_err", 32'(a_err), 32'd0);

    // Illegal op
    a_req(4'h7, 32'h0, 32'h0);
    chk("ill_rv",  32'(a_rv),  32'd1);
    chk("ill_err", 32'(a_err), 32'd0);
    chk("ill_rd",  a_rd, 32'h0);

    // Back-to-back: store accepted in the load's RESP cycle
    a_valid = 1'b1; a_op = 4'h4; a_addr = 32'h8; a_wdata = 32'h0;
    tick();
    chk("b2b_ld_rv", 32'(a_rv), 32'd1);
    chk("b2b_ld_rd", a_rd, 32'h4455_6677);
    chk("b2b_ready", 32'(a_ready), 32'd1);
    a_op = 4'hA; a_addr = 32'h10; a_wdata = 32'hCAFE_F00D;
    tick();
    a_valid = 1'b0;
    chk("b2b_st_rv", 32'(a_rv), 32'd1);
    chk("b2b_st_rd", a_rd, 32'h0);
    a_req(4'h4, 32'h10, 32'h0);
    chk("b2b_rb", a_rd, 32'hCAFE_F00D);

    // Flush during RESP suppresses the response
    a_req(4'h4, 32'h8, 32'h0);
    a_flush = 1'b1;
    #1;
    chk("a_flush_rv", 32'(a_rv), 32'd0);
    chk("a_flush_ready", 32'(a_ready), 32'd0);
    a_flush = 1'b0;
    tick();
    chk("a_flush_after", 32'(a_rv), 32'd0);

    // RD_LATENCY=3 timing
    b_req(4'hA, 32'h0, 32'h0BAD_CAFE);
    chk("b_sw_rv", 32'(b_rv), 32'd1);
    b_req(4'h4, 32'h0, 32'h0);
    chk("b_t1_busy", 32'(b_busy), 32'd1);
    chk("b_t1_rv",   32'(b_rv),   32'd0);
    tick();
    chk("b_t2_busy", 32'(b_busy), 32'd1);
    chk("b_t2_rv",   32'(b_rv),   32'd0);
    tick();
    chk("b_t3_busy", 32'(b_busy), 32'd0);
    chk("b_t3_rv",   32'(b_rv),   32'd1);
    chk("b_t3_rd",   b_rd, 32'h0BAD_CAFE);
    tick();
    chk("b_t4_rv", 32'(b_rv), 32'd0);

    // Flush in RD_WAIT
    b_req(4'h4, 32'h0, 32'h0);
    tick();
    chk("bf_busy", 32'(b_busy), 32'd1);
    b_flush = 1'b1;
    #1;
    chk("bf_ready", 32'(b_ready), 32'd0);
    tick();
    b_flush = 1'b0;
    #1;
    chk("bf_idle_busy", 32'(b_busy), 32'd0);
    chk("bf_idle_rv",   32'(b_rv),   32'd0);
    chk("bf_idle_ready", 32'(b_ready), 32'd1);
    tick();
    chk("bf_norv", 32'(b_rv), 32'd0);

    // Reset pulsed in RD_WAIT
    b_req(4'h4, 32'h0, 32'h0);
    chk("br_busy0", 32'(b_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("br_busy", 32'(b_busy), 32'd0);
    chk("br_rv",   32'(b_rv),   32'd0);
    chk("br_ready", 32'(b_ready), 32'd0);
    chk("br_rd",   b_rd, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("br_norv1", 32'(b_rv), 32'd0);
    tick();
    chk("br_norv2", 32'(b_rv), 32'd0);
    b_req(4'h4, 32'h0, 32'h0);
    tick();
    tick();
    chk("br_ram_kept", b_rd, 32'h0BAD_CAFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
